// File: rtl/router_pkg.sv
// Definitions shared by the router's input FIFOs, arbiters and crossbar.
// The one-hot crossbar-select constants match the arbiter grant encoding.
package router_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    PORT_L,
    PORT_N,
    PORT_E,
    PORT_W,
    PORT_S
  } port_e;

  localparam logic [4:0] XBAR_SEL_N = 5'b00001;
  localparam logic [4:0] XBAR_SEL_E = 5'b00010;
  localparam logic [4:0] XBAR_SEL_W = 5'b00100;
  localparam logic [4:0] XBAR_SEL_S = 5'b01000;
  localparam logic [4:0] XBAR_SEL_L = 5'b10000;

endpackage

// File: rtl/router_input_fifo.sv
// Per-input-port flit buffer: DRTS/CTS handshake on the write side, and a show-ahead
// circular FIFO that pops on any output arbiter's grant.
module router_input_fifo
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic                  CTS,
  output logic                  empty_out,
  output logic                  full_out,
  output logic [DATA_WIDTH-1:0] Data_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [4:0]            read_en_vec;
  logic                  write;
  logic                  read;

  // Grants are laid out in crossbar-select order so the vector mirrors the arbiter encoding.
  assign read_en_vec = {read_en_L, read_en_S, read_en_W, read_en_E, read_en_N};

  assign empty_out = (count == '0);
  assign full_out  = (count == CW'(DEPTH));
  assign Data_out  = mem[rd_ptr];

  assign write = DRTS & CTS;
  assign read  = (|read_en_vec) & ~empty_out;

  // CTS only rises from a not-full state and only for one cycle, so a write can never hit a
  // full FIFO: count may only fall between the CTS decision and the write it grants.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    if (rst) begin
      CTS    <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      CTS <= DRTS & ~CTS & ~full_out;
      if (write) wr_ptr <= wr_ptr + PW'(1);
      if (read)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(write) - CW'(read);
    end
  end

  // NOTE: storage is deliberately not reset; the head is only meaningful while count is non-zero.
  always_ff @(posedge clk) begin
    if (write && !rst) mem[wr_ptr] <= RX;
  end

endmodule

// File: tb/tb_router_input_fifo.sv
// Directed handshake/pointer scenarios followed by a randomised queue-model scoreboard
// for router_input_fifo.
module tb_router_input_fifo;
  import router_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] RX;
  logic          DRTS;
  logic          read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
  logic          CTS, empty_out, full_out;
  logic [DW-1:0] Data_out;

  int n_checks = 0;
  int n_errors = 0;

  router_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .DRTS      (DRTS),
    .read_en_N (read_en_N),
    .read_en_E (read_en_E),
    .read_en_W (read_en_W),
    .read_en_S (read_en_S),
    .read_en_L (read_en_L),
    .CTS       (CTS),
    .empty_out (empty_out),
    .full_out  (full_out),
    .Data_out  (Data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Offer one flit upstream-style: hold DRTS/RX until CTS is seen, then let the write edge pass.
  task automatic offer(input logic [DW-1:0] data, input string tag);
    logic seen;
    seen = 1'b0;
    DRTS = 1'b1;
    RX   = data;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = CTS;
    end
    check({tag, "_cts_seen"}, seen, 1'b1);
    step();
    DRTS = 1'b0;
  endtask

  task automatic pop(input int port);
    read_en_N = (port == 0);
    read_en_E = (port == 1);
    read_en_W = (port == 2);
    read_en_S = (port == 3);
    read_en_L = (port == 4);
    step();
    read_en_N = 1'b0;
    read_en_E = 1'b0;
    read_en_W = 1'b0;
    read_en_S = 1'b0;
    read_en_L = 1'b0;
  endtask

  logic [DW-1:0] q[$];
  logic          m_cts;
  logic          cts_seen;
  logic          wr, rd;
  logic          nxt_cts;
  int            sel;
  int            rd_range;

  initial begin
    RX = '0;
    DRTS = 1'b0;
    read_en_N = 1'b0;
    read_en_E = 1'b0;
    read_en_W = 1'b0;
    read_en_S = 1'b0;
    read_en_L = 1'b0;

    // 1) reset state and a single handshake
    do_reset();
    check("rst_cts", CTS, 1'b0);
    check("rst_empty", empty_out, 1'b1);
    check("rst_full", full_out, 1'b0);
    DRTS = 1'b1;
    RX   = 32'hA5A5_0001;
    step();
    check("t1_cts_pulse", CTS, 1'b1);
    check("t1_empty_before_write", empty_out, 1'b1);
    step();
    DRTS = 1'b0;
    check("t1_empty", empty_out, 1'b0);
    check("t1_data", Data_out, 32'hA5A5_0001);
    check("t1_cts_drop", CTS, 1'b0);
    pop(0);
    check("t1_empty_after_pop", empty_out, 1'b1);

    // 2) fill from a fresh reset, then CTS must stay low while full
    do_reset();
    for (int i = 0; i < DEPTH; i++) offer(32'h10 + i, "t2_fill");
    check("t2_full", full_out, 1'b1);
    check("t2_head", Data_out, 32'h10);
    DRTS = 1'b1;
    RX   = 32'h14;
    cts_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      cts_seen = cts_seen | CTS;
    end
    check("t2_cts_held_low", cts_seen, 1'b0);

    // 3) one pop from full, then the pending flit wraps into slot 0
    pop(1);
    check("t3_data_adv", Data_out, 32'h11);
    check("t3_not_full", full_out, 1'b0);
    check("t3_cts_not_yet", CTS, 1'b0);
    step();
    check("t3_cts_pulse", CTS, 1'b1);
    step();
    DRTS = 1'b0;
    check("t3_full_again", full_out, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      check("t3_drain_data", Data_out, 32'h11 + i);
      pop(1);
    end
    check("t3_drained", empty_out, 1'b1);

    // 4) simultaneous write and pop at count 1
    offer(32'h20, "t4_first");
    DRTS = 1'b1;
    RX   = 32'h21;
    step();
    check("t4_cts", CTS, 1'b1);
    read_en_L = 1'b1;
    step();
    read_en_L = 1'b0;
    DRTS = 1'b0;
    check("t4_empty", empty_out, 1'b0);
    check("t4_full", full_out, 1'b0);
    check("t4_data", Data_out, 32'h21);
    pop(4);
    check("t4_count_was_one", empty_out, 1'b1);

    // 5) pops while empty are ignored
    read_en_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_empty_hold", empty_out, 1'b1);
    end
    read_en_N = 1'b0;
    offer(32'h55, "t5_write");
    check("t5_data", Data_out, 32'h55);
    check("t5_not_empty", empty_out, 1'b0);
    pop(2);
    check("t5_empty_after", empty_out, 1'b1);

    // 6) reset lands on the CTS cycle: flit dropped, re-offer succeeds
    DRTS = 1'b1;
    RX   = 32'h66;
    step();
    check("t6_cts", CTS, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_cts_cleared", CTS, 1'b0);
    check("t6_empty", empty_out, 1'b1);
    step();
    check("t6_cts_reoffer", CTS, 1'b1);
    step();
    DRTS = 1'b0;
    check("t6_data", Data_out, 32'h66);
    check("t6_not_empty", empty_out, 1'b0);
    pop(3);
    check("t6_empty_after", empty_out, 1'b1);

    // Random traffic against a queue model; read pressure drops in the second half so it fills.
    do_reset();
    q.delete();
    m_cts = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      check("sb_cts", CTS, m_cts);
      check("sb_empty", empty_out, q.size() == 0);
      check("sb_full", full_out, q.size() == DEPTH);
      if (!DRTS && $urandom_range(0, 3) != 0) begin
        DRTS = 1'b1;
        RX   = $urandom;
      end
      rd_range = (i < 5000) ? 7 : 14;
      sel = $urandom_range(0, rd_range);
      read_en_N = (sel == 0);
      read_en_E = (sel == 1);
      read_en_W = (sel == 2);
      read_en_S = (sel == 3);
      read_en_L = (sel == 4);
      wr = DRTS && m_cts;
      rd = (sel < 5) && (q.size() != 0);
      nxt_cts = DRTS && !m_cts && (q.size() != DEPTH);
      if (rd) begin
        check("sb_pop_data", Data_out, q[0]);
        void'(q.pop_front());
      end
      if (wr) q.push_back(RX);
      m_cts = nxt_cts;
      step();
      if (wr) DRTS = 1'b0;
    end
    read_en_N = 1'b0;
    read_en_E = 1'b0;
    read_en_W = 1'b0;
    read_en_S = 1'b0;
    read_en_L = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
